// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between an upstream FIFO and fifo_uart_tx.
// The transmitter is the slave: it samples the head word and level, and returns the pop strobe.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
);
    logic [WIDTH-1:0] data_i;
    logic [DEPTH-1:0] size_i;
    logic             getData_o;

    modport master (
        output data_i,
        output size_i,
        input  getData_o
    );

    modport slave (
        input  data_i,
        input  size_i,
        output getData_o
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO, LSB first, 8N1-style frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 7,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fifo_uart_tx_if.slave fifo,
    input  logic          tx_en_i,
    output logic          tx_o,
    output logic          busy_o
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             pop;
    logic             can_pop;
    logic             baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign can_pop   = tx_en_i && (fifo.size_i != '0);
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (can_pop) begin
                    pop     = 1'b1;
                    shift_d = fifo.data_i;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = ^fifo.data_i;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    // Chain straight into the next start bit when more data waits.
                    if (can_pop) begin
                        pop     = 1'b1;
                        shift_d = fifo.data_i;
`ifdef FIFO_UART_TX_PARITY_EN
                        par_d   = ^fifo.data_i;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) baud_d = '0;
        if (rst_i) pop = 1'b0;
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:   tx_d = 1'b1;
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            STOP:   tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign fifo.getData_o = pop;
    assign tx_o           = tx_q;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, WIDTH=8, DEPTH=7.
// Upstream FIFO is a small pointer model; the serial line is sampled every cycle.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    logic tx;
    logic busy;

    logic [7:0] mem [16];
    int rd = 0;
    int wr = 0;
    int pops = 0;
    int n_cmp = 0;
    int n_bad = 0;

    fifo_uart_tx_if #(.WIDTH(8), .DEPTH(7)) bus ();

    assign bus.size_i = 7'(wr - rd);
    assign bus.data_i = mem[rd[3:0]];

    always @(posedge clk) begin
        if (bus.getData_o) begin
            rd   <= rd + 1;
            pops <= pops + 1;
        end
    end

    fifo_uart_tx #(
        .WIDTH(8),
        .DEPTH(7),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .fifo    (bus.slave),
        .tx_en_i (tx_en),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr[3:0]] = d;
        wr = wr + 1;
        #1;
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.getData_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic capture(input int n, output logic [87:0] s);
        s = '0;
        for (int i = 0; i < n; i++) begin
            step();
            s[i] = tx;
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef FIFO_UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    function automatic logic [87:0] expand(input logic [10:0] f, input int nbits);
        logic [87:0] e;
        e = '0;
        for (int i = 0; i < nbits * CPB; i++) e[i] = f[i / CPB];
        return e;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d);
        bit ok;
        logic [87:0] s;
        int p0;
        p0 = pops;
        push(d);
        wait_pop(ok);
        check({tag, "_pop"}, 88'(ok), 88'd1);
        capture(FL, s);
        check({tag, "_line"}, s, expand(exp_frame(d), NB));
        check({tag, "_busy_stop"}, 88'(busy), 88'd1);
        step();
        check({tag, "_busy_end"}, 88'(busy), 88'd0);
        check({tag, "_idle_tx"}, 88'(tx), 88'd1);
        check({tag, "_pops"}, 88'(pops - p0), 88'd1);
    endtask

    initial begin
        bit ok;
        logic [87:0] s;
        logic [87:0] s2;
        int p0;
        int bad_tx;

        step();
        tx_en = 1'b1;
        push(8'h77);
        check("rst_no_pop", 88'(bus.getData_o), 88'd0);
        step();
        step();
        check("rst_tx", 88'(tx), 88'd1);
        check("rst_busy", 88'(busy), 88'd0);
        wr = rd;
        tx_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("rst_pops", 88'(pops), 88'd0);
        tx_en = 1'b1;

        run_frame("a5", 8'hA5);
        run_frame("07", 8'h07);

        p0 = pops;
        push(8'h01);
        push(8'hFF);
        wait_pop(ok);
        check("b2b_pop1", 88'(ok), 88'd1);
        capture(FL, s);
        check("b2b_f1", s, expand(exp_frame(8'h01), NB));
        check("b2b_pop2", 88'(bus.getData_o), 88'd1);
        capture(FL, s2);
        check("b2b_f2", s2, expand(exp_frame(8'hFF), NB));
        step();
        check("b2b_idle", 88'(busy), 88'd0);
        check("b2b_pops", 88'(pops - p0), 88'd2);

        p0 = pops;
        bad_tx = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || bus.getData_o !== 1'b0) bad_tx++;
        end
        check("empty_line", 88'(bad_tx), 88'd0);
        check("empty_pops", 88'(pops - p0), 88'd0);
        tx_en = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        bad_tx = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || bus.getData_o !== 1'b0 || busy !== 1'b0) bad_tx++;
        end
        check("dis_line", 88'(bad_tx), 88'd0);
        check("dis_pops", 88'(pops - p0), 88'd0);
        wr = rd;
        tx_en = 1'b1;
        #1;

        push(8'h3C);
        wait_pop(ok);
        check("mid_pop", 88'(ok), 88'd1);
        capture(16, s);
        check("mid_prefix", s, expand(exp_frame(8'h3C), 4));
        p0 = pops;
        rst = 1'b1;
        #1;
        check("mid_rst_no_pop", 88'(bus.getData_o), 88'd0);
        step();
        check("mid_tx", 88'(tx), 88'd1);
        check("mid_busy", 88'(busy), 88'd0);
        rst = 1'b0;
        bad_tx = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad_tx++;
        end
        check("mid_after_line", 88'(bad_tx), 88'd0);
        check("mid_after_pops", 88'(pops - p0), 88'd0);

        run_frame("5a", 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
